// File: rtl/cache_pkg.sv
// Shared types and constants for the self-addressed 4-way write-back cache controller.
package cache_pkg;

    localparam int TAG_W      = 4;
    localparam int SET_W      = 2;
    localparam int OFF_W      = 2;
    localparam int SETS       = 4;
    localparam int WAYS       = 4;
    localparam int LINE_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    typedef logic [7:0]                  byte_t;
    typedef byte_t [LINE_BYTES-1:0]      line_t;
    typedef logic [1:0]                  way_t;

    // Request address sequence; entry 0 is the rightmost element.
    localparam logic [7:0][7:0] ADDR_ROM = {8'h00, 8'h40, 8'h30, 8'h20,
                                            8'h10, 8'h00, 8'h10, 8'h00};

    function automatic logic [7:0] rom_addr(input logic [2:0] idx);
        return ADDR_ROM[idx];
    endfunction

endpackage

// File: rtl/cache_controller_four_way_set.sv
// Tag/valid/dirty/data/replacement storage for all sets; LRU when CACHE_LRU_EN is defined, else round-robin.
module four_way_set
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SET_W-1:0] set_i,
    input  logic [TAG_W-1:0] tag_i,
    input  way_t             way_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic             byte_we_i,
    input  byte_t            byte_wdata_i,
    input  logic             set_dirty_i,
    input  logic             fill_done_i,
    input  logic             touch_i,
    output logic             hit_o,
    output way_t             hit_way_o,
    output way_t             victim_way_o,
    output logic             victim_valid_o,
    output logic             victim_dirty_o,
    output line_t            line_o,
    output logic [TAG_W-1:0] line_tag_o
);

    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    line_t            data_q  [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
`ifdef CACHE_LRU_EN
    way_t             age_q   [SETS][WAYS];
`else
    way_t             rr_q    [SETS];
    logic             unused_touch;
    assign unused_touch = touch_i;
`endif

    assign line_o     = data_q[set_i][way_i];
    assign line_tag_o = tag_q[set_i][way_i];

    // Hit detection and victim choice; descending loops leave the lowest matching way.
    always_comb begin
        logic inv_found;
        way_t inv_way;
        way_t repl_way;
        way_t vw;
        hit_o     = 1'b0;
        hit_way_o = 2'd0;
        inv_found = 1'b0;
        inv_way   = 2'd0;
        repl_way  = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_o     = hit_o | (valid_q[set_i][w] && (tag_q[set_i][w] == tag_i));
            hit_way_o = (valid_q[set_i][w] && (tag_q[set_i][w] == tag_i)) ? way_t'(w) : hit_way_o;
            inv_way   = !valid_q[set_i][w] ? way_t'(w) : inv_way;
            inv_found = inv_found | !valid_q[set_i][w];
`ifdef CACHE_LRU_EN
            repl_way  = (age_q[set_i][w] == 2'd0) ? way_t'(w) : repl_way;
`endif
        end
`ifndef CACHE_LRU_EN
        repl_way = rr_q[set_i];
`endif
        vw             = inv_found ? inv_way : repl_way;
        victim_way_o   = vw;
        victim_valid_o = valid_q[set_i][vw];
        victim_dirty_o = dirty_q[set_i][vw];
    end

    // Line storage and replacement-state updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
`ifndef CACHE_LRU_EN
                rr_q[s]    <= 2'd0;
`endif
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
`ifdef CACHE_LRU_EN
                    age_q[s][w]  <= way_t'(w);
`endif
                end
            end
        end else begin
            if (byte_we_i) begin
                data_q[set_i][way_i][off_i] <= byte_wdata_i;
            end
            if (set_dirty_i) begin
                dirty_q[set_i][way_i] <= 1'b1;
            end
            if (fill_done_i) begin
                valid_q[set_i][way_i] <= 1'b1;
                dirty_q[set_i][way_i] <= 1'b0;
                tag_q[set_i][way_i]   <= tag_i;
`ifndef CACHE_LRU_EN
                rr_q[set_i]           <= rr_q[set_i] + 2'd1;
`endif
            end
`ifdef CACHE_LRU_EN
            // Age 3 is MRU, age 0 is LRU; ways younger than the touched one age by one.
            if (touch_i) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (way_t'(w) == way_i) begin
                        age_q[set_i][w] <= 2'd3;
                    end else if (age_q[set_i][w] > age_q[set_i][way_i]) begin
                        age_q[set_i][w] <= age_q[set_i][w] - 2'd1;
                    end
                end
            end
`endif
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Self-addressed write-back/write-allocate cache with internal 256-byte backing store.
// Define CACHE_LRU_EN for true-LRU replacement; default is per-set round-robin.
module cache_controller
    import cache_pkg::*;
#(
    parameter logic [7:0] MEM_XOR    = 8'h5A,
    parameter logic [7:0] WDATA_BASE = 8'hC0
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       opcode,
    output logic [7:0] data_out,
    output logic       ready
);

    state_e     state_q;
    logic       ready_q;
    byte_t      data_out_q;
    logic [2:0] idx_q;
    logic [3:0] wcnt_q;
    logic       op_q;
    logic [7:0] addr_q;
    way_t       way_q;
    logic [1:0] cnt_q;
    byte_t      mem_q [256];

    logic             hit_s, victim_valid_s, victim_dirty_s;
    way_t             hit_way_s, victim_way_s;
    line_t            line_s;
    logic [TAG_W-1:0] line_tag_s;
    logic [SET_W-1:0] set_s;
    logic [TAG_W-1:0] tag_s;
    logic [OFF_W-1:0] off_s;
    byte_t            wdata_s;
    logic             byte_we_s, set_dirty_s, fill_done_s, touch_s;

    assign tag_s       = addr_q[7:4];
    assign set_s       = addr_q[3:2];
    assign off_s       = (state_q == ST_FILL) ? cnt_q : addr_q[1:0];
    assign wdata_s     = WDATA_BASE | {4'h0, wcnt_q};
    assign byte_we_s   = (state_q == ST_FILL) || ((state_q == ST_DONE) && op_q);
    assign set_dirty_s = (state_q == ST_DONE) && op_q;
    assign fill_done_s = (state_q == ST_FILL) && (cnt_q == 2'd3);
    assign touch_s     = (state_q == ST_DONE);

    four_way_set u_set (
        .clk           (clk),
        .rst_n         (rst_b),
        .set_i         (set_s),
        .tag_i         (tag_s),
        .way_i         (way_q),
        .off_i         (off_s),
        .byte_we_i     (byte_we_s),
        .byte_wdata_i  ((state_q == ST_FILL) ? mem_q[{tag_s, set_s, cnt_q}] : wdata_s),
        .set_dirty_i   (set_dirty_s),
        .fill_done_i   (fill_done_s),
        .touch_i       (touch_s),
        .hit_o         (hit_s),
        .hit_way_o     (hit_way_s),
        .victim_way_o  (victim_way_s),
        .victim_valid_o(victim_valid_s),
        .victim_dirty_o(victim_dirty_s),
        .line_o        (line_s),
        .line_tag_o    (line_tag_s)
    );

    // Request FSM, backing store and registered outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            data_out_q <= 8'h00;
            idx_q      <= 3'd0;
            wcnt_q     <= 4'd0;
            op_q       <= 1'b0;
            addr_q     <= 8'h00;
            way_q      <= 2'd0;
            cnt_q      <= 2'd0;
            for (int a = 0; a < 256; a++) begin
                mem_q[a] <= 8'(a) ^ MEM_XOR;
            end
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    op_q    <= opcode;
                    addr_q  <= rom_addr(idx_q);
                    state_q <= ST_LOOKUP;
                end
                ST_LOOKUP: begin
                    cnt_q <= 2'd0;
                    if (hit_s) begin
                        way_q   <= hit_way_s;
                        state_q <= ST_DONE;
                    end else begin
                        way_q   <= victim_way_s;
                        state_q <= (victim_valid_s && victim_dirty_s) ? ST_WRITEBACK : ST_FILL;
                    end
                end
                ST_WRITEBACK: begin
                    mem_q[{line_tag_s, set_s, cnt_q}] <= line_s[cnt_q];
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_q    <= 1'b1;
                    data_out_q <= op_q ? wdata_s : line_s[addr_q[1:0]];
                    if (op_q) begin
                        wcnt_q <= wcnt_q + 4'd1;
                    end
                    idx_q   <= idx_q + 3'd1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed scoreboard bench for cache_controller: latency, data, coherence, replacement and reset.
module tb_cache_controller;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       opcode = 1'b0;
    logic [7:0] data_out;
    logic       ready;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] data;
        int         lat;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] prev_data = 8'h00;

    cache_controller dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .opcode  (opcode),
        .data_out(data_out),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request; opcode is flipped after the sample edge to show it is ignored.
    task automatic run_req(input string tag, input logic op, input logic [7:0] exp_data, input int exp_lat);
        exp_t e;
        int   n;
        bit   got;
        e.data = exp_data;
        e.lat  = exp_lat;
        e.tag  = tag;
        sb.push_back(e);
        opcode = op;
        @(posedge clk); #1;
        chk({tag, "_ready_low"}, int'(ready), 0);
        chk({tag, "_hold"}, int'(data_out), int'(prev_data));
        opcode = ~op;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ready) got = 1'b1;
        end
        e = sb.pop_front();
        chk({e.tag, "_latency"}, n, e.lat);
        chk({e.tag, "_data"}, int'(data_out), int'(e.data));
        prev_data = data_out;
    endtask

    initial begin
        #1;
        chk("reset_ready", int'(ready), 0);
        chk("reset_data", int'(data_out), 0);
        @(negedge clk);
        rst_b = 1'b1;

        run_req("r0_rd00_miss",   1'b0, 8'h5A, 6);
        run_req("r1_wr10_miss",   1'b1, 8'hC0, 6);
        run_req("r2_rd00_hit",    1'b0, 8'h5A, 2);
        run_req("r3_wr10_hit",    1'b1, 8'hC1, 2);
        run_req("r4_rd20_miss",   1'b0, 8'h7A, 6);
        run_req("r5_rd30_miss",   1'b0, 8'h6A, 6);
        run_req("r6_rd40_evict",  1'b0, 8'h1A, 6);
        run_req("r7_rd00_dirty",  1'b0, 8'h5A, 10);
        run_req("r0b_rd00_hit",   1'b0, 8'h5A, 2);
        run_req("r1b_rd10_wback", 1'b0, 8'hC1, 6);
        run_req("r2b_rd00_hit",   1'b0, 8'h5A, 2);
        run_req("r3b_wr10_hit",   1'b1, 8'hC2, 2);

        // r4 (addr 20) misses clean; reset while its line is half filled.
        opcode = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midfill_ready", int'(ready), 0);
        rst_b = 1'b0;
        #1;
        chk("midfill_rst_ready", int'(ready), 0);
        chk("midfill_rst_data", int'(data_out), 0);
        @(negedge clk);
        rst_b     = 1'b1;
        prev_data = 8'h00;

        run_req("p0_rd00_miss", 1'b0, 8'h5A, 6);
        run_req("p1_rd10_miss", 1'b0, 8'h4A, 6);
        run_req("p2_rd00_hit",  1'b0, 8'h5A, 2);
        run_req("p3_wr10_hit",  1'b1, 8'hC0, 2);

        @(posedge clk); #1;
        chk("final_ready_pulse", int'(ready), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
